maxnet_controller: RTL
======================

# maxnet_controller

Sequencer and competition datapath for the 4-neuron Maxnet. On `start` it captures the four 32-bit initial values presented by the initial-value memory, runs Maxnet lateral-inhibition iterations until at most one value remains nonzero, and then reports the index and value of the winner. It sits between the initial-value memory and the top-level result logic, and owns all iteration state.

## Interface
- `WIDTH`, 32: data width of each neuron value.
- `EPS_SHIFT`, 3: inhibition weight ε = 2^-EPS_SHIFT.
- `MAX_ITER`, 64: iteration limit before the run is forced to finish.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  **synchronous, active-low** reset.
- `start`  in  1  single-cycle request; sampled in IDLE and DONE only.
- `init_data1..init_data4`  in  WIDTH each  initial values from memory, two's complement.
- `busy`  out  1  high in LOAD, CHECK and ITER.
- `done`  out  1  high in DONE (a level, not a pulse).
- `winner_idx`  out  2  index 0..3 of the winner.
- `winner_val`  out  WIDTH  final value of the winner.
- `iter_count`  out  8  number of completed iterations.
- `timeout`  out  1  the run ended because `MAX_ITER` was reached.
- `no_winner`  out  1  the run ended with all four values at zero.
- `cur_data1..cur_data4`  out  WIDTH each  current neuron registers, for debug.

## Operation
- **States:** IDLE, LOAD, CHECK, ITER, DONE.
- **Reset:** while `rst` = 0 at an edge, state goes to IDLE and every output and register goes to 0.
- **IDLE:** when `start` = 1, go to LOAD.
- **LOAD:**
  - `cur_dataN` ← `init_dataN`; a negative input (MSB set) is clamped to 0.
  - `iter_count` ← 0; go to CHECK.
- **CHECK:** `active` = number of nonzero `cur_data`.
  - `active` ≤ 1: go to DONE.
  - Else, if `iter_count` == `MAX_ITER`: go to DONE with `timeout` set.
  - Else: go to ITER.
- **ITER:** one Maxnet step, all four registers updated in parallel from the old values.
  - `total` = sum of the four values, computed at WIDTH+2 bits (no overflow).
  - `inh_i` = (`total` − `cur_i`) >> `EPS_SHIFT` (logical shift, floor).
  - `new_i` = `cur_i` − `inh_i` if that result is > 0, else 0.
  - `iter_count` += 1; go to CHECK.
- **Entry to DONE:**
  - `winner_idx` = lowest index with nonzero value, or 0 if none.
  - `winner_val` = that value, or 0.
  - `no_winner` = (`active` == 0).
  - `timeout` set as above.
  - `done` = 1.
- **DONE:** outputs hold. When `start` = 1, go to LOAD; `done`, `timeout` and `no_winner` clear on that edge. `winner_idx` and `winner_val` hold until the next entry to DONE.
- `start` is ignored in LOAD, CHECK and ITER.

## Timing
- `start` sampled at edge k → state is LOAD after edge k, and `busy` = 1.
- Inputs are captured at edge k+1.
- Each iteration costs 2 cycles (ITER then CHECK).
- For a run of N iterations, `done` rises after edge k+2+2N, and `busy` falls on the same edge.
- `init_data` must be stable only in the LOAD cycle.
- `rst` low in any state aborts the run within one edge.
- `rst` and `start` active in the same cycle: reset wins.
- Worst-case latency is 2·`MAX_ITER`+2 cycles.

## Test plan
- **Normal competition.** Inputs 100, 80, 60, 40, defaults, `start` at edge k.
  - After iteration 1, `cur_data` = 78, 55, 33, 10.
  - Required result: `done` after edge k+18, `iter_count` = 8, `winner_idx` = 0, `winner_val` = 50, `timeout` = `no_winner` = 0.
- **Trivial runs.**
  - Inputs 0, 0, 7, 0 → `done` after edge k+2, `winner_idx` = 2, `winner_val` = 7, `iter_count` = 0.
  - Inputs all 0 → `done` after edge k+2, `no_winner` = 1, `winner_idx` = 0, `winner_val` = 0.
- **Stall and timeout.** Inputs 50, 50, 50, 50.
  - Values stall at 2, 2, 2, 2 after 8 iterations.
  - Required result: `timeout` = 1 after edge k+130, `iter_count` = 64, `winner_idx` = 0, `winner_val` = 2.
- **Negative clamp.** Inputs 0x80000000, 0xFFFFFFFF, 5, 0 → both negatives load as 0; `winner_idx` = 2, `winner_val` = 5, `iter_count` = 0.
- **Reset mid-run.**
  - Drive `rst` low during ITER of the 100/80/60/40 run → all outputs 0, state IDLE.
  - A later `start` reproduces the full normal-competition result.
- **Start handling.**
  - `start` pulsed during `busy` → no effect on the running result.
  - `start` in DONE → `done` clears next edge, and a new run completes with new inputs.

Source files
------------

// File: rtl/maxnet_controller_if.sv
// Bus between the Maxnet controller, the initial-value memory and result logic.
// The slave modport is the controller side; the master side drives start/init data.
interface maxnet_controller_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] init_data1;
  logic [WIDTH-1:0] init_data2;
  logic [WIDTH-1:0] init_data3;
  logic [WIDTH-1:0] init_data4;
  logic             busy;
  logic             done;
  logic [1:0]       winner_idx;
  logic [WIDTH-1:0] winner_val;
  logic [7:0]       iter_count;
  logic             timeout;
  logic             no_winner;
  logic [WIDTH-1:0] cur_data1;
  logic [WIDTH-1:0] cur_data2;
  logic [WIDTH-1:0] cur_data3;
  logic [WIDTH-1:0] cur_data4;

  modport slave (
    input  start, init_data1, init_data2, init_data3, init_data4,
    output busy, done, winner_idx, winner_val, iter_count, timeout, no_winner,
           cur_data1, cur_data2, cur_data3, cur_data4
  );

  modport master (
    output start, init_data1, init_data2, init_data3, init_data4,
    input  busy, done, winner_idx, winner_val, iter_count, timeout, no_winner,
           cur_data1, cur_data2, cur_data3, cur_data4
  );
endinterface

// File: rtl/maxnet_controller.sv
// 4-neuron Maxnet sequencer: loads initial values, iterates lateral inhibition
// until at most one neuron survives (or the iteration limit hits), reports winner.
module maxnet_controller #(
  parameter int WIDTH     = 32,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 64
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ITER,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q [4];
  logic [WIDTH-1:0] cur_d [4];
  logic [7:0]       iter_q, iter_d;
  logic [1:0]       widx_q, widx_d;
  logic [WIDTH-1:0] wval_q, wval_d;
  logic             timeout_q, timeout_d;
  logic             nowin_q, nowin_d;

  logic [WIDTH-1:0] initVal [4];
  logic [WIDTH-1:0] clamped [4];
  logic [WIDTH+1:0] total;
  logic [WIDTH+1:0] inh     [4];
  logic [WIDTH-1:0] stepped [4];
  logic [2:0]       active;
  logic [1:0]       lowIdx;
  logic [WIDTH-1:0] lowVal;

  assign initVal[0] = bus.init_data1;
  assign initVal[1] = bus.init_data2;
  assign initVal[2] = bus.init_data3;
  assign initVal[3] = bus.init_data4;

  // Negative initial values cannot win, so they enter the competition as zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      clamped[i] = initVal[i][WIDTH-1] ? '0 : initVal[i];
    end
  end

  // One inhibition step; the sum is two bits wider so four values never overflow.
  always_comb begin
    total = '0;
    for (int i = 0; i < 4; i++) begin
      total = total + {2'b00, cur_q[i]};
    end
    for (int i = 0; i < 4; i++) begin
      inh[i]     = (total - {2'b00, cur_q[i]}) >> EPS_SHIFT;
      stepped[i] = ({2'b00, cur_q[i]} > inh[i])
                   ? WIDTH'({2'b00, cur_q[i]} - inh[i]) : '0;
    end
  end

  always_comb begin
    active = '0;
    lowIdx = '0;
    lowVal = '0;
    for (int i = 3; i >= 0; i--) begin
      if (cur_q[i] != '0) begin
        active = active + 3'd1;
        lowIdx = 2'(i);
        lowVal = cur_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    iter_d    = iter_q;
    widx_d    = widx_q;
    wval_d    = wval_q;
    timeout_d = timeout_q;
    nowin_d   = nowin_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_d   = clamped;
        iter_d  = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (active <= 3'd1 || iter_q == 8'(MAX_ITER)) begin
          state_d   = S_DONE;
          widx_d    = lowIdx;
          wval_d    = lowVal;
          nowin_d   = (active == 3'd0);
          timeout_d = (active > 3'd1);
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        cur_d   = stepped;
        iter_d  = iter_q + 8'd1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        if (bus.start) begin
          state_d   = S_LOAD;
          timeout_d = 1'b0;
          nowin_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < 4; i++) cur_q[i] <= '0;
      iter_q    <= '0;
      widx_q    <= '0;
      wval_q    <= '0;
      timeout_q <= 1'b0;
      nowin_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < 4; i++) cur_q[i] <= cur_d[i];
      iter_q    <= iter_d;
      widx_q    <= widx_d;
      wval_q    <= wval_d;
      timeout_q <= timeout_d;
      nowin_q   <= nowin_d;
    end
  end

  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_ITER);
  assign bus.done       = (state_q == S_DONE);
  assign bus.winner_idx = widx_q;
  assign bus.winner_val = wval_q;
  assign bus.iter_count = iter_q;
  assign bus.timeout    = timeout_q;
  assign bus.no_winner  = nowin_q;
  assign bus.cur_data1  = cur_q[0];
  assign bus.cur_data2  = cur_q[1];
  assign bus.cur_data3  = cur_q[2];
  assign bus.cur_data4  = cur_q[3];

endmodule
